e_mod_inv_gen: RTL and testbench

Parametrised modular inverter for the ECC datapath. It computes inv_nu = nu_1^-1 mod modulus for any odd modulus supplied at run time, using the binary extended Euclidean algorithm with one reduction step per clock. It replaces the fixed-prime, fixed-256-bit inverter: curves are selected by the modulus port rather than a hard-wired constant. Non-invertible operands and iteration overruns are reported through an error flag instead of hanging.

---
 rtl/e_mod_inv_gen_if.sv | 23 ++
 rtl/e_mod_inv_gen.sv | 164 ++++++++++++++++
 tb/tb_e_mod_inv_gen.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mod_inv_gen_if.sv
// Handshake and operand bundle for the modular inverter.
// The master drives the request and operands; the slave returns status and result.
interface e_mod_inv_gen_if #(
  parameter int WIDTH = 256
);
  logic             start_inv;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] nu_1;
  logic             busy;
  logic             done_inv;
  logic             inv_err;
  logic [WIDTH-1:0] inv_nu;

  modport master (
    output start_inv, modulus, nu_1,
    input  busy, done_inv, inv_err, inv_nu
  );

  modport slave (
    input  start_inv, modulus, nu_1,
    output busy, done_inv, inv_err, inv_nu
  );
endinterface

// File: rtl/e_mod_inv_gen.sv
// Modular inverter: binary extended Euclid with one reduction step per clock.
// Works for any odd run-time modulus; non-invertible operands and overruns raise inv_err.
module e_mod_inv_gen #(
  parameter int WIDTH    = 256,
  parameter int MAX_ITER = 4 * WIDTH
) (
  input  logic           clk,
  input  logic           reset_n,
  e_mod_inv_gen_if.slave bus
);
  localparam int CW = $clog2(MAX_ITER + 1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] THREE   = {{(WIDTH-2){1'b0}}, 2'b11};
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] u_r, u_s, v_r, v_s, x1_r, x1_s, x2_r, x2_s, p_r, p_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [WIDTH-1:0] res_r, res_s;

  // x/2 mod p; an odd x gets p added first, with the carry kept as the new MSB
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] p);
    if (x[0]) begin
      return WIDTH'(({1'b0, x} + {1'b0, p}) >> 1'b1);
    end else begin
      return {1'b0, x[WIDTH-1:1]};
    end
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] p);
    if (a >= b) begin
      return a - b;
    end else begin
      return WIDTH'({1'b0, a} - {1'b0, b} + {1'b0, p});
    end
  endfunction

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_s = state_r;
    u_s     = u_r;
    v_s     = v_r;
    x1_s    = x1_r;
    x2_s    = x2_r;
    p_s     = p_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    err_s   = err_r;
    res_s   = res_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start_inv) begin
          u_s     = bus.nu_1;
          v_s     = bus.modulus;
          p_s     = bus.modulus;
          x1_s    = ONE;
          x2_s    = ZERO;
          cnt_s   = {CW{1'b0}};
          err_s   = 1'b0;
          res_s   = ZERO;
          busy_s  = 1'b1;
          state_s = CHECK;
        end else begin
          state_s = state_r;
        end
      end
      CHECK: begin
        if (!p_r[0] || (p_r < THREE) || (u_r == ZERO) || (u_r >= p_r)) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        if (u_r == ONE) begin
          res_s   = x1_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else if (v_r == ONE) begin
          res_s   = x2_r;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else if ((u_r == ZERO) || (v_r == ZERO) || (cnt_r == CNT_MAX)) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
          if (!u_r[0]) begin
            u_s  = {1'b0, u_r[WIDTH-1:1]};
            x1_s = half_mod(x1_r, p_r);
          end else if (!v_r[0]) begin
            v_s  = {1'b0, v_r[WIDTH-1:1]};
            x2_s = half_mod(x2_r, p_r);
          end else if (u_r >= v_r) begin
            u_s  = u_r - v_r;
            x1_s = sub_mod(x1_r, x2_r, p_r);
          end else begin
            v_s  = v_r - u_r;
            x2_s = sub_mod(x2_r, x1_r, p_r);
          end
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      u_r     <= ZERO;
      v_r     <= ZERO;
      x1_r    <= ZERO;
      x2_r    <= ZERO;
      p_r     <= ZERO;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      res_r   <= ZERO;
    end else begin
      state_r <= state_s;
      u_r     <= u_s;
      v_r     <= v_s;
      x1_r    <= x1_s;
      x2_r    <= x2_s;
      p_r     <= p_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      res_r   <= res_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done_inv = done_r;
  assign bus.inv_err  = err_r;
  assign bus.inv_nu   = res_r;
endmodule

// File: tb/tb_e_mod_inv_gen.sv
// Self-checking bench: an 8-bit and a 256-bit (secp256k1) inverter against
// brute-force and Fermat-exponentiation reference models.
module tb_e_mod_inv_gen;
  localparam logic [255:0] P256 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int LIM8   = 4 * 8 + 10;
  localparam int LIM256 = 4 * 256 + 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  e_mod_inv_gen_if #(.WIDTH(8))   b8 ();
  e_mod_inv_gen_if #(.WIDTH(256)) b256 ();

  e_mod_inv_gen #(.WIDTH(8))   u8   (.clk(clk), .reset_n(reset_n), .bus(b8));
  e_mod_inv_gen #(.WIDTH(256)) u256 (.clk(clk), .reset_n(reset_n), .bus(b256));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: inverse by exhaustive search; error when the operand is out of range or shares a factor with p
  task automatic ref8(input int p, input int a, output logic [7:0] inv, output logic err);
    inv = 8'd0;
    err = 1'b1;
    if ((p % 2 == 1) && (p >= 3) && (a != 0) && (a < p)) begin
      for (int i = 1; i < p; i++) begin
        if ((a * i) % p == 1) begin
          inv = 8'(i);
          err = 1'b0;
        end
      end
    end
  endtask

  // Reference: a^(p-2) mod p (Fermat, p prime)
  function automatic logic [255:0] modinv256(input logic [255:0] a);
    logic [511:0] r, b, m;
    logic [255:0] e;
    r = 512'd1;
    b = {256'd0, a};
    m = {256'd0, P256};
    e = P256 - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] a;
    for (int i = 0; i < 8; i++) a[i*32 +: 32] = $urandom();
    a = a % P256;
    if (a == 256'd0) a = 256'd1;
    return a;
  endfunction

  task automatic start8(input logic [7:0] p, input logic [7:0] a);
    b8.modulus   = p;
    b8.nu_1      = a;
    b8.start_inv = 1'b1;
    tick();
    b8.start_inv = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (b8.done_inv !== 1'b1 && lat < LIM8) begin
      tick();
      lat++;
    end
    check("done8_seen", b8.done_inv, 1);
  endtask

  task automatic start256(input logic [255:0] a);
    b256.modulus   = P256;
    b256.nu_1      = a;
    b256.start_inv = 1'b1;
    tick();
    b256.start_inv = 1'b0;
  endtask

  task automatic wait256(output int lat);
    lat = 1;
    while (b256.done_inv !== 1'b1 && lat < LIM256) begin
      tick();
      lat++;
    end
    check("done256_seen", b256.done_inv, 1);
  endtask

  initial begin
    int           lat;
    logic [7:0]   e8;
    logic         eerr;
    logic [7:0]   rp, ra;
    logic [255:0] a, exp256;
    logic [256:0] half;
    logic [511:0] prod;
    logic [7:0]   ep [4];
    logic [7:0]   ea [4];
    ep = '{8'd7, 8'd8, 8'd7, 8'd9};
    ea = '{8'd0, 8'd3, 8'd9, 8'd3};

    b8.start_inv = 1'b0;   b8.modulus = 8'd0;     b8.nu_1 = 8'd0;
    b256.start_inv = 1'b0; b256.modulus = 256'd0; b256.nu_1 = 256'd0;
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_busy8", b8.busy, 0);
    check("rst_done8", b8.done_inv, 0);
    check("rst_err8", b8.inv_err, 0);
    check("rst_inv8", b8.inv_nu, 0);
    check("rst_busy256", b256.busy, 0);
    check("rst_done256", b256.done_inv, 0);
    check("rst_err256", b256.inv_err, 0);
    check("rst_inv256", b256.inv_nu, 0);
    reset_n = 1'b1;
    tick();

    // p=7, a=3 and the hold behaviour in DONE
    start8(8'd7, 8'd3);
    check("busy_after_start", b8.busy, 1);
    wait8(lat);
    check("p7a3_inv", b8.inv_nu, 5);
    check("p7a3_err", b8.inv_err, 0);
    check("p7a3_busy_at_done", b8.busy, 0);
    tick();
    check("done_one_cycle", b8.done_inv, 0);
    check("held_inv", b8.inv_nu, 5);
    tick();
    tick();
    check("held_inv_later", b8.inv_nu, 5);
    check("idle_busy", b8.busy, 0);

    // Minimum latency
    start8(8'd251, 8'd1);
    wait8(lat);
    check("a1_lat", lat, 3);
    check("a1_inv", b8.inv_nu, 1);
    check("a1_err", b8.inv_err, 0);

    // Error cases
    for (int i = 0; i < 4; i++) begin
      start8(ep[i], ea[i]);
      wait8(lat);
      check("errcase_err", b8.inv_err, 1);
      check("errcase_inv", b8.inv_nu, 0);
      if (i < 3) check("errcase_lat2", lat, 2);
      else       check("gcd_from_run", lat > 2, 1);
    end

    // Back-to-back: new start in the done_inv cycle
    start8(8'd7, 8'd3);
    wait8(lat);
    check("b2b_first_held", b8.inv_nu, 5);
    b8.nu_1      = 8'd2;
    b8.start_inv = 1'b1;
    tick();
    b8.start_inv = 1'b0;
    check("b2b_done_drop", b8.done_inv, 0);
    check("b2b_busy", b8.busy, 1);
    check("b2b_cleared", b8.inv_nu, 0);
    wait8(lat);
    check("b2b_second_inv", b8.inv_nu, 4);
    check("b2b_second_err", b8.inv_err, 0);

    // Random 8-bit operands, including non-coprime pairs
    for (int i = 0; i < 40; i++) begin
      rp = 8'($urandom_range(3, 255) | 1);
      ra = 8'($urandom_range(1, int'(rp) - 1));
      ref8(int'(rp), int'(ra), e8, eerr);
      start8(rp, ra);
      wait8(lat);
      check("rnd8_inv", b8.inv_nu, e8);
      check("rnd8_err", b8.inv_err, eerr);
    end

    // secp256k1, a=2
    half = {1'b0, P256} + 257'd1;
    start256(256'd2);
    wait256(lat);
    check("k1_a2_inv", b256.inv_nu, half[256:1]);
    check("k1_a2_err", b256.inv_err, 0);
    check("k1_a2_lat", lat <= 4 * 256 + 3, 1);

    for (int i = 0; i < 40; i++) begin
      a = rand256();
      exp256 = modinv256(a);
      start256(a);
      wait256(lat);
      check("k1_rnd_inv", b256.inv_nu, exp256);
      check("k1_rnd_err", b256.inv_err, 0);
      prod = ({256'd0, a} * {256'd0, b256.inv_nu}) % {256'd0, P256};
      check("k1_rnd_prod", prod, 1);
    end

    // Start pulse during RUN is ignored
    a = rand256();
    exp256 = modinv256(a);
    start256(a);
    repeat (20) tick();
    b256.nu_1      = rand256();
    b256.start_inv = 1'b1;
    tick();
    b256.start_inv = 1'b0;
    check("midstart_busy", b256.busy, 1);
    wait256(lat);
    check("midstart_inv", b256.inv_nu, exp256);
    check("midstart_err", b256.inv_err, 0);

    // Reset during RUN aborts without a done pulse
    start256(rand256());
    repeat (20) tick();
    check("prereset_busy", b256.busy, 1);
    reset_n = 1'b0;
    tick();
    check("midrst_busy", b256.busy, 0);
    check("midrst_done", b256.done_inv, 0);
    check("midrst_err", b256.inv_err, 0);
    check("midrst_inv", b256.inv_nu, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("postrst_no_done", b256.done_inv, 0);
      check("postrst_busy", b256.busy, 0);
    end

    a = rand256();
    exp256 = modinv256(a);
    start256(a);
    wait256(lat);
    check("after_rst_inv", b256.inv_nu, exp256);
    check("after_rst_err", b256.inv_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
